fir_tap_dispatch: RTL and testbench

//  Input-side sequencer of the 4-lane FIR datapath; the fan-out counterpart of the MAC-output summer.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_tap_dispatch_if.sv | 29 ++
 rtl/fir_coef_bank.sv | 34 +++
 rtl/fir_tap_dispatch.sv | 141 ++++++++++++++
 tb/tb_fir_tap_dispatch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and tap-count helper for the 4-lane FIR
// input sequencer.
package fir_pkg;

  localparam int NUM_MAC = 4;
  localparam int TAP_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  function automatic int total_taps(input int taps_per_mac);
    return NUM_MAC * taps_per_mac;
  endfunction

endpackage

// File: rtl/fir_tap_dispatch_if.sv
// Sample/coefficient input bus and per-lane MAC operand bus of the FIR
// tap dispatcher; slave is the dispatcher, master drives it.
interface fir_tap_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);

  logic                      iEnSample600k;
  logic [DATA_W-1:0]         iFirIn;
  logic                      iCoefWr;
  logic [fir_pkg::TAP_W-1:0] iCoefAddr;
  logic [COEF_W-1:0]         iCoefData;
  logic [DATA_W-1:0]         oSmpl1, oSmpl2, oSmpl3, oSmpl4;
  logic [COEF_W-1:0]         oCoef1, oCoef2, oCoef3, oCoef4;
  logic                      oEnMac, oMacClr, oEnDelay, oBusy, oOverrun;

  modport master (
    output iEnSample600k, iFirIn, iCoefWr, iCoefAddr, iCoefData,
    input  oSmpl1, oSmpl2, oSmpl3, oSmpl4, oCoef1, oCoef2, oCoef3, oCoef4,
    input  oEnMac, oMacClr, oEnDelay, oBusy, oOverrun
  );

  modport slave (
    input  iEnSample600k, iFirIn, iCoefWr, iCoefAddr, iCoefData,
    output oSmpl1, oSmpl2, oSmpl3, oSmpl4, oCoef1, oCoef2, oCoef3, oCoef4,
    output oEnMac, oMacClr, oEnDelay, oBusy, oOverrun
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one write port, one combinational read port per
// MAC lane. Write gating (state, address range) is decided by the parent.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int DEPTH  = 40
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              wr_en,
  input  logic [TAP_W-1:0]  wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [TAP_W-1:0]  rd_addr [NUM_MAC],
  output logic [COEF_W-1:0] rd_data [NUM_MAC]
);

  logic [COEF_W-1:0] mem_r [DEPTH];

  // Storage: cleared on reset, single write port
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Per-lane combinational read
  always_comb begin
    for (int j = 0; j < NUM_MAC; j++) rd_data[j] = mem_r[rd_addr[j]];
  end

endmodule

// File: rtl/fir_tap_dispatch.sv
// Input-side sequencer of the 4-lane FIR: holds the sample delay line, walks
// the tap index and issues registered sample/coef pairs to the MAC lanes.
module fir_tap_dispatch
  import fir_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int TAPS_PER_MAC = 10
) (
  input logic               iClk12M,
  input logic               iRst,
  fir_tap_dispatch_if.slave bus
);

  localparam int               TOTAL  = total_taps(TAPS_PER_MAC);
  localparam logic [TAP_W-1:0] LAST_K = TAP_W'(TAPS_PER_MAC - 1);

  fsm_state_t        state_r, state_nxt_s;
  logic [TAP_W-1:0]  k_r, k_nxt_s;
  logic              accept_s;
  logic              coef_we_s;
  logic [DATA_W-1:0] dly_r       [TOTAL];
  logic [TAP_W-1:0]  lane_addr_s [NUM_MAC];
  logic [COEF_W-1:0] lane_coef_s [NUM_MAC];
  logic [DATA_W-1:0] smpl_r      [NUM_MAC];
  logic [COEF_W-1:0] coef_r      [NUM_MAC];
  logic              en_mac_r, mac_clr_r, en_delay_r, busy_r, overrun_r;

  // Next-state and tap-counter logic
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.iEnSample600k) begin
          accept_s    = 1'b1;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        k_nxt_s     = '0;
        state_nxt_s = RUN;
      end
      RUN: begin
        if (k_r == LAST_K) begin
          state_nxt_s = DONE;
        end else begin
          k_nxt_s = k_r + TAP_W'(1'b1);
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign coef_we_s = (state_r == IDLE) && bus.iCoefWr && (int'(bus.iCoefAddr) < TOTAL);

  // Operands are registered from the next tap index, so address with k_nxt
  always_comb begin
    for (int j = 0; j < NUM_MAC; j++) lane_addr_s[j] = TAP_W'(j * TAPS_PER_MAC) + k_nxt_s;
  end

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .DEPTH  (TOTAL)
  ) u_coef_bank (
    .iClk12M (iClk12M),
    .iRst    (iRst),
    .wr_en   (coef_we_s),
    .wr_addr (bus.iCoefAddr),
    .wr_data (bus.iCoefData),
    .rd_addr (lane_addr_s),
    .rd_data (lane_coef_s)
  );

  // FSM state and tap counter
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_r <= IDLE;
      k_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  // Sample delay line; d[0] is the newest sample
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      for (int i = 0; i < TOTAL; i++) dly_r[i] <= '0;
    end else if (accept_s) begin
      for (int i = TOTAL - 1; i > 0; i--) dly_r[i] <= dly_r[i-1];
      dly_r[0] <= bus.iFirIn;
    end
  end

  // Registered outputs; operands only move while a run is presenting taps
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      en_mac_r   <= 1'b0;
      mac_clr_r  <= 1'b0;
      en_delay_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      for (int j = 0; j < NUM_MAC; j++) begin
        smpl_r[j] <= '0;
        coef_r[j] <= '0;
      end
    end else begin
      en_mac_r   <= (state_nxt_s == RUN);
      mac_clr_r  <= (state_nxt_s == RUN) && (k_nxt_s == '0);
      en_delay_r <= (state_nxt_s == DONE);
      busy_r     <= (state_nxt_s != IDLE);
      overrun_r  <= bus.iEnSample600k && (state_r != IDLE);
      if (state_nxt_s == RUN) begin
        for (int j = 0; j < NUM_MAC; j++) begin
          smpl_r[j] <= dly_r[lane_addr_s[j]];
          coef_r[j] <= lane_coef_s[j];
        end
      end
    end
  end

  assign bus.oSmpl1   = smpl_r[0];
  assign bus.oSmpl2   = smpl_r[1];
  assign bus.oSmpl3   = smpl_r[2];
  assign bus.oSmpl4   = smpl_r[3];
  assign bus.oCoef1   = coef_r[0];
  assign bus.oCoef2   = coef_r[1];
  assign bus.oCoef3   = coef_r[2];
  assign bus.oCoef4   = coef_r[3];
  assign bus.oEnMac   = en_mac_r;
  assign bus.oMacClr  = mac_clr_r;
  assign bus.oEnDelay = en_delay_r;
  assign bus.oBusy    = busy_r;
  assign bus.oOverrun = overrun_r;

endmodule

// File: tb/tb_fir_tap_dispatch.sv
// Self-checking bench for fir_tap_dispatch: directed scenarios plus a random
// soak, compared against an array model of the delay line and coefficient bank.
module tb_fir_tap_dispatch;

  localparam int T  = 10;
  localparam int N  = 4 * T;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;

  fir_tap_dispatch_if #(.DATA_W(DW), .COEF_W(CW)) bus ();

  fir_tap_dispatch #(
    .DATA_W       (DW),
    .COEF_W       (CW),
    .TAPS_PER_MAC (T)
  ) dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] dq [N];
  logic [CW-1:0] cq [N];
  logic [DW-1:0] smpl_o [4];
  logic [CW-1:0] coef_o [4];
  int n_chk = 0;
  int n_pass = 0;
  int n_dly = 0;
  int n_ovr = 0;

  assign smpl_o[0] = bus.oSmpl1;
  assign smpl_o[1] = bus.oSmpl2;
  assign smpl_o[2] = bus.oSmpl3;
  assign smpl_o[3] = bus.oSmpl4;
  assign coef_o[0] = bus.oCoef1;
  assign coef_o[1] = bus.oCoef2;
  assign coef_o[2] = bus.oCoef3;
  assign coef_o[3] = bus.oCoef4;

  always @(negedge clk) begin
    if (bus.oEnDelay) n_dly++;
    if (bus.oOverrun) n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.iEnSample600k = 1'b0;
    bus.iFirIn        = '0;
    bus.iCoefWr       = 1'b0;
    bus.iCoefAddr     = '0;
    bus.iCoefData     = '0;
  endtask

  task automatic clear_model;
    for (int i = 0; i < N; i++) begin
      dq[i] = '0;
      cq[i] = '0;
    end
  endtask

  task automatic coef_wr(input logic [5:0] a, input logic [CW-1:0] v);
    bus.iCoefWr   = 1'b1;
    bus.iCoefAddr = a;
    bus.iCoefData = v;
    if (int'(a) < N) cq[a] = v;
    tick;
    bus.iCoefWr = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enmac"}, 32'(bus.oEnMac), 32'd0);
    chk({tag, "_clr"},   32'(bus.oMacClr), 32'd0);
    chk({tag, "_endly"}, 32'(bus.oEnDelay), 32'd0);
    chk({tag, "_busy"},  32'(bus.oBusy), 32'd0);
    chk({tag, "_ovr"},   32'(bus.oOverrun), 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_smpl"}, 32'(smpl_o[j]), 32'd0);
      chk({tag, "_coef"}, 32'(coef_o[j]), 32'd0);
    end
  endtask

  // One complete run started from IDLE; optional overrun strobe at cycle
  // ovr_at, ignored coef write at cycle wr_at, same-cycle coef write via wr0.
  task automatic run(input logic [DW-1:0] s, input int ovr_at, input int wr_at,
                     input logic wr0, input logic [5:0] a0, input logic [CW-1:0] v0);
    int k;
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = s;
    for (int i = N - 1; i > 0; i--) dq[i] = dq[i-1];
    dq[0] = s;
    if (wr0) begin
      bus.iCoefWr   = 1'b1;
      bus.iCoefAddr = a0;
      bus.iCoefData = v0;
      if (int'(a0) < N) cq[a0] = v0;
    end
    for (int cyc = 1; cyc <= T + 3; cyc++) begin
      tick;
      idle_inputs();
      chk("en_mac",   32'(bus.oEnMac),   32'(cyc >= 2 && cyc <= T + 1));
      chk("mac_clr",  32'(bus.oMacClr),  32'(cyc == 2));
      chk("en_delay", 32'(bus.oEnDelay), 32'(cyc == T + 2));
      chk("busy",     32'(bus.oBusy),    32'(cyc <= T + 2));
      chk("overrun",  32'(bus.oOverrun), 32'(ovr_at > 0 && cyc == ovr_at + 1));
      if (cyc >= 2 && cyc <= T + 1) begin
        k = cyc - 2;
        for (int j = 0; j < 4; j++) begin
          chk("smpl", 32'(smpl_o[j]), 32'(dq[j*T + k]));
          chk("coef", 32'(coef_o[j]), 32'(cq[j*T + k]));
        end
      end else if (cyc > T + 1) begin
        chk("hold_smpl", 32'(smpl_o[3]), 32'(dq[N-1]));
        chk("hold_coef", 32'(coef_o[3]), 32'(cq[N-1]));
      end
      if (cyc == ovr_at) begin
        bus.iEnSample600k = 1'b1;
        bus.iFirIn        = 16'hDEAD;
      end
      if (cyc == wr_at) begin
        bus.iCoefWr   = 1'b1;
        bus.iCoefAddr = 6'd3;
        bus.iCoefData = 16'h7FFF;
      end
    end
  endtask

  initial begin
    int dly0;
    int ovr0;
    idle_inputs();
    clear_model();
    rst = 1'b1;
    tick;
    tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    // Impulse
    for (int i = 0; i < N; i++) coef_wr(6'(i), 16'(i + 1));
    run(16'd1, 0, 0, 1'b0, 6'd0, 16'd0);
    gap(7);
    for (int r = 0; r < 3; r++) begin
      run(16'd0, 0, 0, 1'b0, 6'd0, 16'd0);
      gap(7);
    end

    // Coefficient write in the same cycle as the strobe is used by that run
    run(16'h0042, 0, 0, 1'b1, 6'd0, 16'h1234);
    gap(7);

    // Ramp
    for (int r = 1; r <= N; r++) begin
      run(16'(r), 0, 0, 1'b0, 6'd0, 16'd0);
      gap(7);
    end

    // Overrun 5 cycles after the accepting strobe
    ovr0 = n_ovr;
    dly0 = n_dly;
    run(16'h0ABC, 5, 0, 1'b0, 6'd0, 16'd0);
    chk("ovr_count", 32'(n_ovr - ovr0), 32'd1);
    chk("ovr_dly_count", 32'(n_dly - dly0), 32'd1);
    gap(7);
    run(16'h0BCD, 0, 0, 1'b0, 6'd0, 16'd0);
    gap(7);

    // Coefficient gating: write during RUN, then out-of-range write in IDLE
    run(16'h0055, 0, 4, 1'b0, 6'd0, 16'd0);
    coef_wr(6'd40, 16'h7FFF);
    gap(6);
    run(16'h0066, 0, 0, 1'b0, 6'd0, 16'd0);
    gap(7);

    // Reset mid-run at k=4
    dly0 = n_dly;
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = 16'h0999;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick;
      idle_inputs();
      chk("abort_en_mac", 32'(bus.oEnMac), 32'(cyc >= 2));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_all_zero("abort");
    clear_model();
    gap(15);
    chk("abort_no_dly", 32'(n_dly - dly0), 32'd0);
    run(16'h0777, 0, 0, 1'b0, 6'd0, 16'd0);
    gap(7);

    // Soak with random samples and coefficients
    for (int i = 0; i < N; i++) coef_wr(6'(i), 16'($urandom));
    ovr0 = n_ovr;
    dly0 = n_dly;
    for (int r = 0; r < 200; r++) begin
      run(16'($urandom), 0, 0, 1'($urandom), 6'($urandom_range(0, 47)), 16'($urandom));
      for (int w = 0; w < 3; w++) coef_wr(6'($urandom_range(0, 47)), 16'($urandom));
      gap(4);
    end
    chk("soak_overrun", 32'(n_ovr - ovr0), 32'd0);
    chk("soak_en_delay", 32'(n_dly - dly0), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
